frame_align_supervisor: RTL and testbench
=========================================

Name: frame_align_supervisor

Overview:
- Sequences the per-VFAT frame aligners, one channel at a time.
- Scans every unmasked channel. Resets any channel that is not aligned or has latched unstable, then waits for it to report aligned or time out.
- Sits between the trigger-alignment array and the slow-control register block.
- Drives the per-channel aligner reset and reports aggregate alignment health.

Parameters:
- NUM_VFATS, 24, number of frame_aligner channels supervised.
- RESET_CYCLES, 4, number of clocks the aligner reset is held high.
- TIMEOUT_W, 16, width of the wait-for-aligned timeout counter.
- RETRY_W, 4, width of the per-channel retry counter.

Ports:
- clock  in  1  fabric clock, same domain as the aligners.
- reset_n  in  1  synchronous reset, active-low.
- enable_i  in  1  supervisor run enable; 0 freezes the FSM in IDLE.
- realign_all_i  in  1  single-cycle pulse: clear all status and realign every unmasked channel.
- vfat_mask_i  in  NUM_VFATS  1 = channel ignored (never reset, never counted).
- sot_is_aligned_i  in  NUM_VFATS  per-channel aligned flag.
- sot_unstable_i  in  NUM_VFATS  per-channel sticky unstable flag.
- timeout_i  in  TIMEOUT_W  clocks to wait for aligned after a reset; 0 is treated as 1.
- max_retries_i  in  RETRY_W  resets attempted before a channel is declared failed.
- aligner_reset_o  out  NUM_VFATS  per-channel aligner reset, at most one bit high at a time.
- busy_o  out  1  FSM is not in IDLE or SCAN.
- active_ch_o  out  5  channel under service; holds its last value otherwise.
- failed_o  out  NUM_VFATS  sticky: retries exhausted.
- all_aligned_o  out  1  every unmasked, non-failed channel aligned, and none failed.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, channel pointer=0.
  - All outputs 0; retry counters 0.
  - Any asserted aligner_reset_o drops on the next edge.
- State IDLE:
  - If enable_i=1, go to SCAN on the next clock.
  - realign_all_i in IDLE clears failed_o and the retries, then goes to SCAN if enabled.
- State SCAN evaluates the pointer channel ch each cycle:
  - If it is masked, aligned with unstable=0, or failed: pointer <= (ch==NUM_VFATS-1) ? 0 : ch+1. One channel per clock; wrap-around is mandatory.
  - Otherwise: latch active_ch_o=ch and go to RESET.
- State RESET:
  - aligner_reset_o[ch]=1 for exactly RESET_CYCLES clocks.
  - Retry counter[ch] increments, saturating at its maximum value.
  - Then go to WAIT.
- State WAIT:
  - Timeout counter starts at 0 on entry.
  - If sot_is_aligned_i[ch]=1 and sot_unstable_i[ch]=0: clear retry[ch], advance the pointer, go to SCAN.
  - Else if counter==timeout_i−1:
    - If retry[ch]≥max_retries_i, set failed_o[ch], advance the pointer, go to SCAN.
    - Otherwise go to RESET for the same ch.
  - max_retries_i=0 means a single attempt, then failed.
- all_aligned_o is registered: one-clock latency from the inputs.
- Simultaneous events:
  - realign_all_i beats everything. From any state it deasserts aligner_reset_o, clears failed_o and the retries, sets pointer=0, and goes to SCAN (IDLE if enable_i=0).
  - enable_i=0 mid-service: finish the current RESET pulse, then go to IDLE. WAIT aborts immediately.
  - Mask asserted on the active channel during RESET or WAIT: drop reset, advance the pointer, go to SCAN. No failure is recorded.
- Latency: a misaligned channel is reset at most NUM_VFATS+1 clocks after its flag drops, when no other channel is in service.

Optional Feature:
- Macro: FRAME_ALIGN_ERR_CNT_EN.
- With the macro:
  - Adds output err_cnt_o [8*NUM_VFATS]: per-channel 8-bit saturating counters.
  - A counter increments on each rising edge of sot_unstable_i[ch] and on each timeout of ch.
  - Saturates at 255. Cleared by reset_n and realign_all_i.
- Without the macro: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (trig_align_pkg):
  - State enum: IDLE, SCAN, RESET, WAIT.
  - Constant MAX_VFATS=24.
  - Error-counter width constant ERR_CNT_W=8.
- One sub-module, align_err_counter:
  - Single-channel saturating counter with edge detect.
  - Instantiated NUM_VFATS times under the macro.

Test Plan:
1. All 24 channels aligned, enable_i=1 → aligner_reset_o stays 0, pointer wraps 23→0, all_aligned_o=1 one clock after the inputs settle.
2. Channel 5 aligned=0; model asserts aligned 10 clocks after the reset falls; timeout_i=100 → aligner_reset_o[5] high for exactly 4 clocks, retry cleared, all_aligned_o=1.
3. Channel 7 never aligns; timeout_i=20, max_retries_i=3 → three 4-clock reset pulses, each followed by a 20-clock wait. failed_o[7]=1 and all_aligned_o=0 afterwards; SCAN then skips channel 7.
4. Channels 3 and 12 both misaligned → channel 3 serviced first, then 12. No overlap of aligner_reset_o bits.
5. realign_all_i during WAIT on channel 7, with failed_o[2]=1 → next clock aligner_reset_o=0, failed_o=0, pointer=0, state=SCAN.
6. vfat_mask_i[9]=1 with channel 9 unstable → never reset, all_aligned_o unaffected. With FRAME_ALIGN_ERR_CNT_EN, 300 unstable edges on channel 4 → err_cnt_o[4]=255.

Source files
------------

// File: rtl/trig_align_pkg.sv
// Shared types and constants for the trigger-alignment supervisor slice.
package trig_align_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    RESET = 2'd2,
    WAIT  = 2'd3
  } sup_state_e;

  localparam int MAX_VFATS = 24;
  localparam int CH_W      = $clog2(MAX_VFATS);
  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/align_err_counter.sv
// Single-channel saturating error counter: counts rising edges of the
// unstable flag plus wait-for-aligned timeouts reported by the supervisor.
module align_err_counter
  import trig_align_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 unstable,
  input  logic                 timeout_hit,
  output logic [ERR_CNT_W-1:0] count
);

  logic               unstable_q;
  logic [ERR_CNT_W:0] sum;

  // Add both event sources in one step so a coincident edge and timeout both count
  always_comb begin
    sum = {1'b0, count}
        + (ERR_CNT_W+1)'(unstable & ~unstable_q)
        + (ERR_CNT_W+1)'(timeout_hit);
  end

  // Edge-detect register and saturating count, cleared by reset or realign
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      unstable_q <= 1'b0;
      count      <= '0;
    end else if (clear) begin
      unstable_q <= unstable;
      count      <= '0;
    end else begin
      unstable_q <= unstable;
      count      <= sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
    end
  end

endmodule

// File: rtl/frame_align_supervisor.sv
// Frame-align supervisor: walks the VFAT channels one at a time, pulses the
// aligner reset of any channel that is misaligned or latched unstable, waits
// for it to realign, and declares it failed once its retries are used up.
// Optional build macro FRAME_ALIGN_ERR_CNT_EN adds per-channel error counters
// on err_cnt_o.
module frame_align_supervisor
  import trig_align_pkg::*;
#(
  parameter int NUM_VFATS    = 24,
  parameter int RESET_CYCLES = 4,
  parameter int TIMEOUT_W    = 16,
  parameter int RETRY_W      = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable_i,
  input  logic                 realign_all_i,
  input  logic [NUM_VFATS-1:0] vfat_mask_i,
  input  logic [NUM_VFATS-1:0] sot_is_aligned_i,
  input  logic [NUM_VFATS-1:0] sot_unstable_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic [RETRY_W-1:0]   max_retries_i,
  output logic [NUM_VFATS-1:0] aligner_reset_o,
  output logic                 busy_o,
  output logic [CH_W-1:0]      active_ch_o,
  output logic [NUM_VFATS-1:0] failed_o,
  output logic                 all_aligned_o
`ifdef FRAME_ALIGN_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W*NUM_VFATS-1:0] err_cnt_o
`endif
);

  localparam int             RC_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_VFATS - 1);

  sup_state_e           state;
  logic [CH_W-1:0]      ptr;
  logic [RC_W-1:0]      rst_cnt;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [TIMEOUT_W-1:0] tmo_last;
  logic [RETRY_W-1:0]   retry [NUM_VFATS];
  logic                 scan_skip;
  logic                 ch_good;
  logic                 wait_timeout;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (c == LAST_CH) ? '0 : c + CH_W'(1);
  endfunction

  function automatic logic [NUM_VFATS-1:0] onehot(input logic [CH_W-1:0] c);
    logic [NUM_VFATS-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  assign tmo_last = (timeout_i == '0) ? '0 : timeout_i - TIMEOUT_W'(1);
  assign busy_o   = (state == RESET) || (state == WAIT);

  // Per-cycle decisions on the scanned channel and the channel in service
  always_comb begin
    scan_skip    = vfat_mask_i[ptr] || failed_o[ptr] ||
                   (sot_is_aligned_i[ptr] && !sot_unstable_i[ptr]);
    ch_good      = sot_is_aligned_i[active_ch_o] && !sot_unstable_i[active_ch_o];
    wait_timeout = (state == WAIT) && !realign_all_i && enable_i &&
                   !vfat_mask_i[active_ch_o] && !ch_good && (tmo_cnt == tmo_last);
  end

  // Main supervisor FSM; realign overrides everything, mask drops service early
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      ptr             <= '0;
      active_ch_o     <= '0;
      aligner_reset_o <= '0;
      failed_o        <= '0;
      rst_cnt         <= '0;
      tmo_cnt         <= '0;
      for (int i = 0; i < NUM_VFATS; i++) retry[i] <= '0;
    end else if (realign_all_i) begin
      aligner_reset_o <= '0;
      failed_o        <= '0;
      ptr             <= '0;
      state           <= enable_i ? SCAN : IDLE;
      for (int i = 0; i < NUM_VFATS; i++) retry[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_i) state <= SCAN;
        end
        SCAN: begin
          if (!enable_i) begin
            state <= IDLE;
          end else if (scan_skip) begin
            ptr <= next_ch(ptr);
          end else begin
            active_ch_o     <= ptr;
            aligner_reset_o <= onehot(ptr);
            rst_cnt         <= '0;
            state           <= RESET;
            if (retry[ptr] != '1) retry[ptr] <= retry[ptr] + RETRY_W'(1);
          end
        end
        RESET: begin
          if (vfat_mask_i[active_ch_o]) begin
            aligner_reset_o <= '0;
            ptr             <= next_ch(active_ch_o);
            state           <= SCAN;
          end else if (rst_cnt == RC_LAST) begin
            aligner_reset_o <= '0;
            tmo_cnt         <= '0;
            state           <= enable_i ? WAIT : IDLE;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        WAIT: begin
          if (vfat_mask_i[active_ch_o]) begin
            ptr   <= next_ch(active_ch_o);
            state <= SCAN;
          end else if (!enable_i) begin
            state <= IDLE;
          end else if (ch_good) begin
            retry[active_ch_o] <= '0;
            ptr                <= next_ch(active_ch_o);
            state              <= SCAN;
          end else if (wait_timeout) begin
            if (retry[active_ch_o] >= max_retries_i) begin
              failed_o[active_ch_o] <= 1'b1;
              ptr                   <= next_ch(active_ch_o);
              state                 <= SCAN;
            end else begin
              aligner_reset_o <= onehot(active_ch_o);
              rst_cnt         <= '0;
              state           <= RESET;
              if (retry[active_ch_o] != '1)
                retry[active_ch_o] <= retry[active_ch_o] + RETRY_W'(1);
            end
          end else begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Aggregate health: every unmasked channel aligned and no unmasked channel failed
  always_ff @(posedge clock) begin
    if (!reset_n) all_aligned_o <= 1'b0;
    else          all_aligned_o <= (&(sot_is_aligned_i | vfat_mask_i)) &&
                                   !(|(failed_o & ~vfat_mask_i));
  end

`ifdef FRAME_ALIGN_ERR_CNT_EN
  logic [NUM_VFATS-1:0] tmo_hit;

  // One-hot timeout strobe for the channel currently being waited on
  always_comb begin
    tmo_hit = '0;
    if (wait_timeout) tmo_hit[active_ch_o] = 1'b1;
  end

  for (genvar g = 0; g < NUM_VFATS; g++) begin : g_err
    align_err_counter u_err (
      .clock       (clock),
      .reset_n     (reset_n),
      .clear       (realign_all_i),
      .unstable    (sot_unstable_i[g]),
      .timeout_hit (tmo_hit[g]),
      .count       (err_cnt_o[g*ERR_CNT_W +: ERR_CNT_W])
    );
  end
`endif

endmodule

// File: tb/tb_frame_align_supervisor.sv
// Testbench for frame_align_supervisor: a behavioural aligner model reacts to
// the reset pulses, scenarios push the expected pulse sequence into a queue,
// and a monitor process matches every observed pulse against it.
module tb_frame_align_supervisor;
  import trig_align_pkg::*;

  localparam int N  = 24;
  localparam int RC = 4;
  localparam int TW = 16;
  localparam int RW = 4;

  typedef struct {
    int ch;
    int gap;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable_i = 1'b0;
  logic          realign_all_i = 1'b0;
  logic [N-1:0]  vfat_mask_i = '0;
  logic [N-1:0]  sot_is_aligned_i = '1;
  logic [N-1:0]  sot_unstable_i = '0;
  logic [TW-1:0] timeout_i = 16'd30;
  logic [RW-1:0] max_retries_i = 4'd2;
  logic [N-1:0]  aligner_reset_o;
  logic          busy_o;
  logic [CH_W-1:0] active_ch_o;
  logic [N-1:0]  failed_o;
  logic          all_aligned_o;
`ifdef FRAME_ALIGN_ERR_CNT_EN
  logic [ERR_CNT_W*N-1:0] err_cnt_o;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   ch_delay [N];
  int   ch_cnt   [N];

  logic [N-1:0] mon_prev = '0;
  int           mon_width = 0;
  int           mon_gap = 0;

  logic [N-1:0] rnd_mask, rnd_mis, rnd_bad;

  frame_align_supervisor #(
    .NUM_VFATS(N), .RESET_CYCLES(RC), .TIMEOUT_W(TW), .RETRY_W(RW)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .enable_i         (enable_i),
    .realign_all_i    (realign_all_i),
    .vfat_mask_i      (vfat_mask_i),
    .sot_is_aligned_i (sot_is_aligned_i),
    .sot_unstable_i   (sot_unstable_i),
    .timeout_i        (timeout_i),
    .max_retries_i    (max_retries_i),
    .aligner_reset_o  (aligner_reset_o),
    .busy_o           (busy_o),
    .active_ch_o      (active_ch_o),
    .failed_o         (failed_o),
    .all_aligned_o    (all_aligned_o)
`ifdef FRAME_ALIGN_ERR_CNT_EN
    ,
    .err_cnt_o        (err_cnt_o)
`endif
  );

  always #5 clock = ~clock;

  // Global watchdog so a hung design still terminates
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; the aligner model reacts to the reset it sees
  task automatic tick();
    @(negedge clock);
    for (int c = 0; c < N; c++) begin
      if (aligner_reset_o[c]) begin
        sot_is_aligned_i[c] = 1'b0;
        sot_unstable_i[c]   = 1'b0;
        ch_cnt[c]           = ch_delay[c];
      end else if (ch_cnt[c] > 0) begin
        ch_cnt[c]--;
        if (ch_cnt[c] == 0) sot_is_aligned_i[c] = 1'b1;
      end
    end
  endtask

  // Monitor: every reset pulse must match the next expected one
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (aligner_reset_o != '0 && aligner_reset_o != mon_prev) begin
          int idx;
          idx = -1;
          for (int c = 0; c < N; c++) if (aligner_reset_o[c]) idx = c;
          checkOutput("reset_onehot", 64'($onehot(aligner_reset_o)), 64'd1);
          checkOutput("busy_in_pulse", 64'(busy_o), 64'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_pulse: got channel %0d expected none", idx);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("pulse_channel", 64'(idx), 64'(e.ch));
            if (e.gap >= 0) checkOutput("retry_gap", 64'(mon_gap), 64'(e.gap));
          end
          mon_width = 1;
        end else if (aligner_reset_o != '0) begin
          mon_width++;
        end else if (mon_prev != '0) begin
          checkOutput("pulse_width", 64'(mon_width), 64'(RC));
          mon_gap = 1;
        end else begin
          mon_gap++;
        end
        mon_prev = aligner_reset_o;
      end else begin
        mon_prev = '0;
      end
    end
  end

  task automatic waitQueueEmpty(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 6000) begin
      tick();
      k++;
    end
    checkOutput(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Model a scenario from the rules: ascending service, retries, failures
  task automatic applyStimulus(input logic [N-1:0] mask, input logic [N-1:0] misal,
                               input logic [N-1:0] bad, input int tmo, input int maxr,
                               input int dly);
    int           teff;
    int           pulses;
    int           r;
    logic [N-1:0] mis;
    logic [N-1:0] exp_failed;
    teff       = (tmo == 0) ? 1 : tmo;
    pulses     = (maxr == 0) ? 1 : maxr;
    mis        = misal | bad;
    exp_failed = bad & ~mask;
    for (int c = 0; c < N; c++) begin
      if (!mask[c] && mis[c]) begin
        if (bad[c]) begin
          for (int k = 0; k < pulses; k++) exp_q.push_back('{c, (k == 0) ? -1 : teff});
        end else begin
          exp_q.push_back('{c, -1});
        end
      end
    end
    timeout_i     = TW'(tmo);
    max_retries_i = RW'(maxr);
    vfat_mask_i   = mask;
    for (int c = 0; c < N; c++) begin
      ch_cnt[c]   = -1;
      ch_delay[c] = bad[c] ? -1 : ((dly > 0) ? dly : int'($urandom_range(1, teff / 2)));
      if (mis[c]) begin
        r = int'($urandom_range(0, 2));
        sot_is_aligned_i[c] = (r == 2);
        sot_unstable_i[c]   = (r != 0);
      end else begin
        sot_is_aligned_i[c] = 1'b1;
        sot_unstable_i[c]   = 1'b0;
      end
    end
    realign_all_i = 1'b1;
    tick();
    realign_all_i = 1'b0;
    waitQueueEmpty("scenario_pulses_done");
    repeat (RC + teff + N + 10) tick();
    checkOutput("failed_set", 64'(failed_o), 64'(exp_failed));
    checkOutput("all_aligned", 64'(all_aligned_o), 64'(exp_failed == '0));
    checkOutput("busy_idle", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int k;
    int x;
    for (int c = 0; c < N; c++) begin
      ch_delay[c] = 1;
      ch_cnt[c]   = -1;
    end
    enable_i = 1'b1;
    repeat (3) tick();
    checkOutput("reset_aligner_reset", 64'(aligner_reset_o), 64'd0);
    checkOutput("reset_failed", 64'(failed_o), 64'd0);
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    checkOutput("reset_all_aligned", 64'(all_aligned_o), 64'd0);
    checkOutput("reset_active_ch", 64'(active_ch_o), 64'd0);
    reset_n = 1'b1;

    $display("[TB] directed scenarios");
    applyStimulus('0, '0, '0, 30, 2, 0);
    applyStimulus('0, N'(1) << 5, '0, 100, 2, 10);
    applyStimulus('0, N'(1) << 7, N'(1) << 7, 20, 3, 0);
    applyStimulus('0, (N'(1) << 3) | (N'(1) << 12), '0, 40, 1, 0);
    applyStimulus(N'(1) << 9, N'(1) << 9, N'(1) << 9, 20, 1, 0);
    applyStimulus('0, N'(1) << 1, N'(1) << 1, 0, 2, 0);
    applyStimulus('0, N'(1) | (N'(1) << 23), N'(1) << 23, 12, 0, 0);

    $display("[TB] random scenarios");
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < N; c++) begin
        rnd_mask[c] = ($urandom_range(0, 7) == 0);
        rnd_mis[c]  = ($urandom_range(0, 5) == 0);
        rnd_bad[c]  = rnd_mis[c] && ($urandom_range(0, 2) == 0);
      end
      applyStimulus(rnd_mask, rnd_mis, rnd_bad, int'($urandom_range(8, 40)),
                    int'($urandom_range(0, 3)), 0);
    end

    $display("[TB] realign during wait");
    exp_q.push_back('{2, -1});
    exp_q.push_back('{7, -1});
    timeout_i     = 16'd10;
    max_retries_i = 4'd0;
    vfat_mask_i   = '0;
    for (int c = 0; c < N; c++) begin
      ch_cnt[c]   = -1;
      ch_delay[c] = -1;
    end
    sot_is_aligned_i    = '1;
    sot_unstable_i      = '0;
    sot_is_aligned_i[2] = 1'b0;
    sot_is_aligned_i[7] = 1'b0;
    realign_all_i = 1'b1;
    tick();
    realign_all_i = 1'b0;
    k = 0;
    while (!aligner_reset_o[7] && k < 500) begin tick(); k++; end
    while (aligner_reset_o[7] && k < 500) begin tick(); k++; end
    tick();
    tick();
    checkOutput("pre_realign_failed2", 64'(failed_o[2]), 64'd1);
    checkOutput("pre_realign_busy", 64'(busy_o), 64'd1);
    sot_is_aligned_i = '1;
    sot_unstable_i   = '0;
    realign_all_i    = 1'b1;
    tick();
    realign_all_i = 1'b0;
    checkOutput("realign_reset_clear", 64'(aligner_reset_o), 64'd0);
    checkOutput("realign_failed_clear", 64'(failed_o), 64'd0);
    checkOutput("realign_busy", 64'(busy_o), 64'd0);
    waitQueueEmpty("realign_pulses_done");
    repeat (40) tick();

    $display("[TB] enable gating and all_aligned latency");
    timeout_i = 16'd30;
    checkOutput("aa_before", 64'(all_aligned_o), 64'd1);
    enable_i = 1'b0;
    repeat (3) tick();
    sot_is_aligned_i[9] = 1'b0;
    checkOutput("aa_same_cycle", 64'(all_aligned_o), 64'd1);
    tick();
    checkOutput("aa_one_clock", 64'(all_aligned_o), 64'd0);
    k = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (aligner_reset_o != '0 || busy_o) k++;
    end
    checkOutput("disabled_no_service", 64'(k), 64'd0);
    ch_delay[9] = 3;
    exp_q.push_back('{9, -1});
    enable_i = 1'b1;
    waitQueueEmpty("enable_pulse_done");
    repeat (40) tick();
    checkOutput("aa_after_enable", 64'(all_aligned_o), 64'd1);

    $display("[TB] service latency");
    x = int'($urandom_range(0, N - 1));
    ch_delay[x] = 2;
    exp_q.push_back('{x, -1});
    sot_is_aligned_i[x] = 1'b0;
    k = 0;
    while (!aligner_reset_o[x] && k < N + 5) begin tick(); k++; end
    checkOutput("reset_latency_ok", 64'(k <= N + 1), 64'd1);
    waitQueueEmpty("latency_pulse_done");
    repeat (40) tick();

`ifdef FRAME_ALIGN_ERR_CNT_EN
    $display("[TB] error counter saturation");
    vfat_mask_i   = N'(1) << 4;
    realign_all_i = 1'b1;
    tick();
    realign_all_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      sot_unstable_i[4] = 1'b1;
      tick();
      sot_unstable_i[4] = 1'b0;
      tick();
    end
    tick();
    checkOutput("err_cnt_sat", 64'(err_cnt_o[4*ERR_CNT_W +: ERR_CNT_W]), 64'd255);
    checkOutput("err_cnt_quiet", 64'(err_cnt_o[0 +: ERR_CNT_W]), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
